// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the
// sequential binary-to-BCD converter.
package bcd_pkg;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_NINE       = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// start/busy/out_valid handshake and result bus
// between a producer and the BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     lz_mask;
  logic                  overflow;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  out_valid,
    input  bcd,
    input  lz_mask,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output out_valid,
    output bcd,
    output lz_mask,
    output overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble step:
// add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH)
                 ? i_digit + BCD_ADJ_ADD
                 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter,
// one input bit per clock, with overflow and blanking mask.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic          clk_100mhz,
  input  logic          rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int INT_DIGITS = (WIDTH*30103)/100000 + 1;
  localparam int ACC_W      = 4*INT_DIGITS;
  localparam int CNT_W      = $clog2(WIDTH+1);
  localparam int BCD_W      = 4*DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);
  localparam logic [DIGITS-1:0] LZ_RST =
    {{(DIGITS-1){1'b1}}, 1'b0};

  state_t              r_state;
  logic [WIDTH-1:0]    r_shreg;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_valid;
  logic [BCD_W-1:0]    r_bcd;
  logic [DIGITS-1:0]   r_lz;
  logic                r_ovf;

  logic [ACC_W-1:0]       w_adj;
  logic [ACC_W+WIDTH-1:0] w_next;
  logic                   w_ovf;
  logic                   w_zero;
  logic [DIGITS-1:0]      w_lz;
  logic [BCD_W-1:0]       w_bcd;

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_next = {w_adj, r_shreg} << 1;

  // Digits above DIGITS only ever hold a nonzero value on overflow
  always_comb begin
    w_ovf  = 1'b0;
    w_zero = 1'b1;
    w_lz   = '0;
    for (int i = DIGITS; i < INT_DIGITS; i++) begin
      w_ovf = w_ovf | (|r_acc[4*i +: 4]);
    end
    for (int i = DIGITS-1; i >= 1; i--) begin
      w_zero  = w_zero & (r_acc[4*i +: 4] == 4'd0);
      w_lz[i] = w_zero;
    end
    w_bcd = r_acc[BCD_W-1:0];
    if (w_ovf) begin
      w_bcd = {DIGITS{BCD_NINE}};
      w_lz  = '0;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_bcd   <= '0;
      r_lz    <= LZ_RST;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_shreg <= bus.bin_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {r_acc, r_shreg} <= w_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_bcd   <= w_bcd;
          r_lz    <= w_lz;
          r_ovf   <= w_ovf;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.bcd       = r_bcd;
  assign bus.lz_mask   = r_lz;
  assign bus.overflow  = r_ovf;

endmodule
